// File: rtl/parity_serializer.sv
// Serial parity generator: accepts a WIDTH-bit word on load/ready, shifts it out
// LSB-first and appends an even (ODD=0) or odd (ODD=1) parity bit.
module parity_serializer #(
   parameter int WIDTH = 8,
   parameter bit ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             is_parity,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_shift;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_acc;
   logic               w_accept;

   // ready depends on state only, so the accept term never loops back onto load
   assign ready    = (r_state != SHIFT);
   assign w_accept = load && ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SHIFT;
         SHIFT:   if (r_cnt == LAST) w_next = PARITY;
         PARITY:  w_next = w_accept ? SHIFT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      sout       = 1'b0;
      sout_valid = 1'b0;
      is_parity  = 1'b0;
      done       = 1'b0;
      case (r_state)
         SHIFT: begin
            sout       = r_shift[0];
            sout_valid = 1'b1;
         end
         PARITY: begin
            sout       = r_acc;
            sout_valid = 1'b1;
            is_parity  = 1'b1;
            done       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_acc   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= '0;
            r_acc   <= ODD;
         end else if (r_state == SHIFT) begin
            // accumulator folds in the bit currently on sout
            r_shift <= r_shift >> 1;
            r_acc   <= r_acc ^ r_shift[0];
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
